// File: rtl/booth_seq_mul_if.sv
// booth_seq_mul_if
// Handshake and data bundle for the sequential Booth multiplier.
//   start : request a multiply (driven by master)
//   a, b  : signed multiplicand / multiplier (driven by master)
//   sgn   : 1 = signed, 0 = unsigned operands (only with BOOTH_UNSIGNED_EN)
//   busy  : operation in progress (driven by slave)
//   done  : one-cycle pulse when c takes a new result (driven by slave)
//   c     : 2*WIDTH-bit product (driven by slave)
// Optional feature macro: BOOTH_UNSIGNED_EN (adds the sgn signal).
interface booth_seq_mul_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
`ifdef BOOTH_UNSIGNED_EN
    logic                   sgn;
`endif
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     c;

    modport master (
`ifdef BOOTH_UNSIGNED_EN
        output sgn,
`endif
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  c
    );

    modport slave (
`ifdef BOOTH_UNSIGNED_EN
        input  sgn,
`endif
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output c
    );
endinterface

// File: rtl/booth_seq_mul.sv
// booth_seq_mul
// Multi-cycle radix-2 Booth multiplier: one Booth step per clock.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : booth_seq_mul_if.slave (start, a, b, [sgn], busy, done, c)
// Optional feature macro: BOOTH_UNSIGNED_EN
//   defined   -> sgn selects signed (WIDTH steps) or unsigned (WIDTH+1 steps)
//   undefined -> signed only, WIDTH steps
// An operation takes N steps after the accept edge, then one DONE cycle, so
// back-to-back operations with start held high repeat every N+1 cycles.
module booth_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    booth_seq_mul_if.slave  bus
);

`ifdef BOOTH_UNSIGNED_EN
    // Extra bit on Q and M lets unsigned operands be treated as positive
    // signed (WIDTH+1)-bit values; A needs one more bit above that.
    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
`else
    localparam int AW = WIDTH + 1;
    localparam int QW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [AW-1:0]      m_r;
    logic [AW-1:0]      acc_r;
    logic [QW-1:0]      q_r;
    logic               qm1_r;
    logic               busy_r;
    logic               done_r;
    logic [PW-1:0]      c_r;
`ifdef BOOTH_UNSIGNED_EN
    logic               sgn_r;
`endif

    logic [AW-1:0]      sum_s;
    logic [AW-1:0]      acc_nxt_s;
    logic [QW-1:0]      q_nxt_s;
    logic [AW+QW-1:0]   full_s;
    logic [PW-1:0]      prod_s;
    logic [AW-1:0]      m_load_s;
    logic [QW-1:0]      q_load_s;
    logic [CW-1:0]      n_load_s;

    // Operand extension and iteration count chosen at accept time.
    always_comb begin
`ifdef BOOTH_UNSIGNED_EN
        q_load_s = {1'b0, bus.b};
        if (bus.sgn) begin
            m_load_s = {{2{bus.a[WIDTH-1]}}, bus.a};
            n_load_s = CW'(WIDTH);
        end else begin
            m_load_s = {2'b00, bus.a};
            n_load_s = CW'(WIDTH + 1);
        end
`else
        q_load_s = bus.b;
        m_load_s = {bus.a[WIDTH-1], bus.a};
        n_load_s = CW'(WIDTH);
`endif
    end

    // One Booth step: add/subtract M on {Q0,q-1}, then arithmetic shift right.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], qm1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
        {acc_nxt_s, q_nxt_s} = {sum_s[AW-1], sum_s, q_r[QW-1:1]};
        full_s = {acc_nxt_s, q_nxt_s};
`ifdef BOOTH_UNSIGNED_EN
        // In signed mode only WIDTH of the WIDTH+1 Q bits are consumed, so the
        // unused zero top bit of Q ends up in Q[0] and the product sits one up.
        if (sgn_r) begin
            prod_s = full_s[PW:1];
        end else begin
            prod_s = full_s[PW-1:0];
        end
`else
        prod_s = full_s[PW-1:0];
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            m_r     <= {AW{1'b0}};
            acc_r   <= {AW{1'b0}};
            q_r     <= {QW{1'b0}};
            qm1_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            c_r     <= {PW{1'b0}};
`ifdef BOOTH_UNSIGNED_EN
            sgn_r   <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        m_r     <= m_load_s;
                        q_r     <= q_load_s;
                        acc_r   <= {AW{1'b0}};
                        qm1_r   <= 1'b0;
                        cnt_r   <= n_load_s;
`ifdef BOOTH_UNSIGNED_EN
                        sgn_r   <= bus.sgn;
`endif
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    q_r   <= q_nxt_s;
                    qm1_r <= q_r[0];
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        c_r     <= prod_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.c    = c_r;

endmodule
